// File: rtl/teclado_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : teclado_ctrl
// Brief    : Keypad front end - synchronise, debounce, decode, BCD entry and
//            operand/operator token handoff to the ALU sequencer.
// Revision : 1.0  initial release
// ============================================================================
module teclado_ctrl #(
    parameter int NDIG         = 4,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          key_code,
    input  logic                key_da,
    output logic                key_pulse,
    output logic [3:0]          key_val,
    output logic [4*NDIG-1:0]   operand,
    output logic [3:0]          ndig,
    output logic                ovf,
    output logic                tok_valid,
    input  logic                tok_ready,
    output logic [3:0]          tok_op,
    output logic [4*NDIG-1:0]   tok_operand,
    output logic [3:0]          tok_ndig
);

    localparam int                 c_cnt_w      = $clog2(DEBOUNCE_CYC + 1);
    localparam int                 c_opnd_w     = 4 * NDIG;
    localparam logic [c_cnt_w-1:0] c_press_last = c_cnt_w'(DEBOUNCE_CYC);
    localparam logic [c_cnt_w-1:0] c_rel_last   = c_cnt_w'(DEBOUNCE_CYC - 1);
    localparam logic [3:0]         c_ndig_max   = 4'(NDIG);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_press   = 3'd1;
    localparam logic [2:0] c_st_capture = 3'd2;
    localparam logic [2:0] c_st_token   = 3'd3;
    localparam logic [2:0] c_st_rel     = 3'd4;

    logic                 r_da_m, r_da_s;
    logic [3:0]           r_code_m, r_code_s;
    logic [2:0]           r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [3:0]           w_dec;
    logic                 w_is_digit, w_is_clear;
    logic [c_opnd_w-1:0]  w_dig_ext;

    logic                 r_key_pulse;
    logic [3:0]           r_key_val;
    logic [c_opnd_w-1:0]  r_operand;
    logic [3:0]           r_ndig;
    logic                 r_ovf;
    logic                 r_tok_valid;
    logic [3:0]           r_tok_op;
    logic [c_opnd_w-1:0]  r_tok_operand;
    logic [3:0]           r_tok_ndig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_da_m   <= 1'b0;
            r_da_s   <= 1'b0;
            r_code_m <= 4'h0;
            r_code_s <= 4'h0;
        end else begin
            r_da_m   <= key_da;
            r_da_s   <= r_da_m;
            r_code_m <= key_code;
            r_code_s <= r_code_m;
        end
    end

    always_comb begin
        w_dec = 4'hF;
        case (r_code_s)
            4'b1000: w_dec = 4'h0;
            4'b0011: w_dec = 4'h1;
            4'b1011: w_dec = 4'h2;
            4'b0111: w_dec = 4'h3;
            4'b0001: w_dec = 4'h4;
            4'b1001: w_dec = 4'h5;
            4'b0101: w_dec = 4'h6;
            4'b0010: w_dec = 4'h7;
            4'b1010: w_dec = 4'h8;
            4'b0110: w_dec = 4'h9;
            4'b0000: w_dec = 4'hF;
            4'b0100: w_dec = 4'hE;
            4'b1111: w_dec = 4'hD;
            4'b1101: w_dec = 4'hC;
            4'b1110: w_dec = 4'hB;
            4'b1100: w_dec = 4'hA;
            default: w_dec = 4'hF;
        endcase
    end

    assign w_is_digit = (w_dec <= 4'd9);
    assign w_is_clear = (w_dec == 4'hF);
    assign w_dig_ext  = c_opnd_w'(w_dec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Press counter runs 1..DEBOUNCE_CYC; with the registered outputs this
    // places key_pulse DEBOUNCE_CYC+3 edges after key_da is first sampled.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle: begin
                if (r_da_s) begin
                    w_state_nxt = c_st_press;
                    w_cnt_nxt   = c_cnt_w'(1);
                end
            end
            c_st_press: begin
                if (!r_da_s) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_press_last) begin
                    w_state_nxt = c_st_capture;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_capture: begin
                w_cnt_nxt   = '0;
                w_state_nxt = (w_is_digit || w_is_clear) ? c_st_rel : c_st_token;
            end
            c_st_token: begin
                if (r_tok_valid && tok_ready) begin
                    w_state_nxt = c_st_rel;
                end
            end
            c_st_rel: begin
                if (r_da_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_rel_last) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_pulse   <= 1'b0;
            r_key_val     <= 4'h0;
            r_operand     <= '0;
            r_ndig        <= 4'h0;
            r_ovf         <= 1'b0;
            r_tok_valid   <= 1'b0;
            r_tok_op      <= 4'h0;
            r_tok_operand <= '0;
            r_tok_ndig    <= 4'h0;
        end else begin
            r_key_pulse <= (r_state == c_st_capture);
            if (r_state == c_st_capture) begin
                r_key_val <= w_dec;
                if (w_is_digit) begin
                    if (r_ndig < c_ndig_max) begin
                        r_operand <= (r_operand << 4) | w_dig_ext;
                        r_ndig    <= r_ndig + 4'd1;
                    end else begin
                        r_ovf <= 1'b1;
                    end
                end else if (w_is_clear) begin
                    r_operand <= '0;
                    r_ndig    <= 4'h0;
                    r_ovf     <= 1'b0;
                end else begin
                    r_tok_op      <= w_dec;
                    r_tok_operand <= r_operand;
                    r_tok_ndig    <= r_ndig;
                end
            end
            if (r_state == c_st_token) begin
                if (r_tok_valid && tok_ready) begin
                    r_tok_valid <= 1'b0;
                    r_operand   <= '0;
                    r_ndig      <= 4'h0;
                    r_ovf       <= 1'b0;
                end else begin
                    r_tok_valid <= 1'b1;
                end
            end
        end
    end

    assign key_pulse   = r_key_pulse;
    assign key_val     = r_key_val;
    assign operand     = r_operand;
    assign ndig        = r_ndig;
    assign ovf         = r_ovf;
    assign tok_valid   = r_tok_valid;
    assign tok_op      = r_tok_op;
    assign tok_operand = r_tok_operand;
    assign tok_ndig    = r_tok_ndig;

endmodule
`default_nettype wire

// File: tb/tb_teclado_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_teclado_ctrl
// Brief    : Self-checking bench for teclado_ctrl: directed keypad scenarios
//            followed by random key sequences against a decimal entry model.
// Revision : 1.0  initial release
// ============================================================================
module tb_teclado_ctrl;

    localparam int NDIG  = 4;
    localparam int DEB   = 16;
    localparam int C_LAT = DEB + 4;   // g_cyc index of the edge DEB+3 after the first sampling edge

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        key_code;
    logic              key_da;
    logic              tok_ready;
    logic              key_pulse;
    logic [3:0]        key_val;
    logic [4*NDIG-1:0] operand;
    logic [3:0]        ndig;
    logic              ovf;
    logic              tok_valid;
    logic [3:0]        tok_op;
    logic [4*NDIG-1:0] tok_operand;
    logic [3:0]        tok_ndig;

    always #5 clk = ~clk;

    teclado_ctrl #(.NDIG(NDIG), .DEBOUNCE_CYC(DEB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_code   (key_code),
        .key_da     (key_da),
        .key_pulse  (key_pulse),
        .key_val    (key_val),
        .operand    (operand),
        .ndig       (ndig),
        .ovf        (ovf),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_op     (tok_op),
        .tok_operand(tok_operand),
        .tok_ndig   (tok_ndig)
    );

    logic [3:0] dig_code [10] = '{4'b1000, 4'b0011, 4'b1011, 4'b0111, 4'b0001,
                                  4'b1001, 4'b0101, 4'b0010, 4'b1010, 4'b0110};
    logic [3:0] op_code  [5]  = '{4'b1100, 4'b1110, 4'b1101, 4'b1111, 4'b0100};
    logic [3:0] dec_tab  [16];

    int n_cmp = 0;
    int n_err = 0;
    int g_cyc, g_pulses, g_first;
    logic [3:0] g_kv;

    // Entry model kept as a decimal number plus digit count.
    int         m_val, m_ndig;
    logic       m_ovf, m_tok;
    logic [3:0] m_tok_op;
    int         m_tok_val, m_tok_nd;

    function automatic logic [4*NDIG-1:0] to_bcd(input int v);
        logic [4*NDIG-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_key_pulse"}, 32'(key_pulse), 0);
        check({tag, "_key_val"}, 32'(key_val), 0);
        check({tag, "_operand"}, 32'(operand), 0);
        check({tag, "_ndig"}, 32'(ndig), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
        check({tag, "_tok_valid"}, 32'(tok_valid), 0);
        check({tag, "_tok_op"}, 32'(tok_op), 0);
        check({tag, "_tok_operand"}, 32'(tok_operand), 0);
        check({tag, "_tok_ndig"}, 32'(tok_ndig), 0);
    endtask

    task automatic start_key(input logic [3:0] code);
        key_code = code;
        g_pulses = 0;
        g_first  = -1;
        g_cyc    = 0;
        g_kv     = 4'h0;
    endtask

    task automatic seg(input logic lvl, input int n);
        key_da = lvl;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            g_cyc++;
            if (key_pulse === 1'b1) begin
                g_pulses++;
                if (g_first < 0) begin
                    g_first = g_cyc;
                    g_kv    = key_val;
                end
            end
        end
    endtask

    task automatic model_clear();
        m_val  = 0;
        m_ndig = 0;
        m_ovf  = 1'b0;
        m_tok  = 1'b0;
    endtask

    task automatic apply_model(input logic [3:0] code);
        int v;
        v = int'(dec_tab[code]);
        check("key_val", 32'(g_kv), 32'(v));
        if (v <= 9) begin
            if (m_ndig < NDIG) begin
                m_val  = m_val * 10 + v;
                m_ndig = m_ndig + 1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (v == 15) begin
            model_clear();
        end else begin
            m_tok     = 1'b1;
            m_tok_op  = 4'(v);
            m_tok_val = m_val;
            m_tok_nd  = m_ndig;
        end
        check("operand", 32'(operand), 32'(to_bcd(m_val)));
        check("ndig", 32'(ndig), 32'(m_ndig));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("tok_valid", 32'(tok_valid), 32'(m_tok));
        if (m_tok) begin
            check("tok_op", 32'(tok_op), 32'(m_tok_op));
            check("tok_operand", 32'(tok_operand), 32'(to_bcd(m_tok_val)));
            check("tok_ndig", 32'(tok_ndig), 32'(m_tok_nd));
        end
    endtask

    task automatic key_step(input logic [3:0] code, input int hold, input int low);
        start_key(code);
        seg(1'b1, hold);
        seg(1'b0, low);
        check("pulse_count", 32'(g_pulses), 1);
        check("pulse_latency", 32'(g_first), 32'(C_LAT));
        apply_model(code);
    endtask

    task automatic handshake(input int wait_n);
        for (int i = 0; i < wait_n; i++) begin
            @(posedge clk); #1;
            check("tok_hold_valid", 32'(tok_valid), 1);
            check("tok_hold_op", 32'(tok_op), 32'(m_tok_op));
            check("tok_hold_operand", 32'(tok_operand), 32'(to_bcd(m_tok_val)));
            check("tok_hold_ndig", 32'(tok_ndig), 32'(m_tok_nd));
        end
        tok_ready = 1'b1;
        @(posedge clk); #1;
        tok_ready = 1'b0;
        model_clear();
        check("hs_tok_valid", 32'(tok_valid), 0);
        check("hs_operand", 32'(operand), 0);
        check("hs_ndig", 32'(ndig), 0);
        check("hs_ovf", 32'(ovf), 0);
        repeat (DEB + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 10; d++) dec_tab[dig_code[d]] = 4'(d);
        dec_tab[4'b0000] = 4'hF;
        for (int k = 0; k < 5; k++) dec_tab[op_code[k]] = 4'hA + 4'(k);

        rst_n = 1'b1; key_da = 1'b0; key_code = 4'h0; tok_ready = 1'b0;
        model_clear();
        #1 rst_n = 1'b0;
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Digits 1 then 2; tok_ready high with no token must do nothing.
        key_step(4'b0011, 40, DEB + 6);
        tok_ready = 1'b1;
        key_step(4'b1011, 40, DEB + 6);
        tok_ready = 1'b0;
        check("tp_operand_12", 32'(operand), 32'h0012);
        check("tp_ndig_2", 32'(ndig), 2);

        // Fill the entry and overflow with a fifth digit.
        key_step(4'b0000, 40, DEB + 6);
        key_step(dig_code[9], 40, DEB + 6);
        key_step(dig_code[8], 40, DEB + 6);
        key_step(dig_code[7], 40, DEB + 6);
        key_step(dig_code[6], 40, DEB + 6);
        key_step(dig_code[5], 40, DEB + 6);
        check("tp_operand_9876", 32'(operand), 32'h9876);
        check("tp_ndig_4", 32'(ndig), 4);
        check("tp_ovf", 32'(ovf), 1);
        check("tp_kval_5", 32'(g_kv), 5);

        // 4,2 then key A (code 1111 -> D) with the consumer stalled.
        key_step(4'b0000, 40, DEB + 6);
        key_step(dig_code[4], 40, DEB + 6);
        key_step(dig_code[2], 40, DEB + 6);
        key_step(4'b1111, 40, DEB + 6);
        check("tp_tok_op_D", 32'(tok_op), 32'hD);
        check("tp_tok_operand_42", 32'(tok_operand), 32'h0042);
        check("tp_tok_ndig_2", 32'(tok_ndig), 2);
        handshake(10);

        // Two short key_da glitches must not register.
        key_step(dig_code[3], 40, DEB + 6);
        start_key(dig_code[7]);
        seg(1'b1, 10);
        seg(1'b0, 5);
        seg(1'b1, 10);
        seg(1'b0, DEB + 8);
        check("glitch_pulses", 32'(g_pulses), 0);
        check("glitch_operand", 32'(operand), 32'(to_bcd(m_val)));

        // Release bounce, then a second hold before the release debounce expires.
        start_key(dig_code[5]);
        seg(1'b1, 40);
        seg(1'b0, 5);
        seg(1'b1, 3);
        seg(1'b0, 8);
        seg(1'b1, 40);
        seg(1'b0, 40);
        check("bounce_pulses", 32'(g_pulses), 1);
        check("bounce_latency", 32'(g_first), 32'(C_LAT));
        apply_model(dig_code[5]);

        // Clear after 3,1.
        key_step(4'b0000, 40, DEB + 6);
        key_step(dig_code[3], 40, DEB + 6);
        key_step(dig_code[1], 40, DEB + 6);
        key_step(4'b0000, 40, DEB + 6);
        check("tp_clear_operand", 32'(operand), 0);
        check("tp_clear_ndig", 32'(ndig), 0);
        check("tp_clear_tok", 32'(tok_valid), 0);

        // Asynchronous reset while a token is pending.
        key_step(dig_code[7], 40, DEB + 6);
        key_step(4'b1101, 40, DEB + 6);
        #2 rst_n = 1'b0;
        #1;
        check_zero("rst_in_token");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;

        // Random key sequences against the model.
        for (int n = 0; n < 24; n++) begin
            int sel;
            logic [3:0] code;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) code = 4'b0000;
            else if (sel == 1) code = op_code[$urandom_range(0, 4)];
            else code = dig_code[$urandom_range(0, 9)];
            tok_ready = (sel == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            key_step(code, int'($urandom_range(DEB + 6, 40)), DEB + 4 + int'($urandom_range(0, 4)));
            tok_ready = 1'b0;
            if (m_tok) handshake(int'($urandom_range(0, 6)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
